// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: command sequencer driving the S/R inputs of an SR flip-flop.
// Set/reset/toggle requests are queued in a small FIFO. Each one becomes a
// HOLD-cycle pulse on exactly one of S or R, followed by a one-cycle guard
// (CHECK) in which both lines are low.
//
// Optional feature macro: SR_CHECK_EN
//   defined   - Q is compared with the expected value at the end of CHECK;
//               a mismatch sets the sticky err flag, err_clr clears it.
//   undefined - CHECK remains as a timing guard only; err is tied to 0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid, cmd_op      command request (00 nop, 01 set, 10 reset, 11 toggle)
//   cmd_ready              FIFO not full (registered)
//   Q                      flip-flop output fed back for toggles and checking
//   err_clr                synchronous clear of err
//   S, R                   registered set/reset drive, never both high
//   busy                   FSM active or FIFO non-empty (registered)
//   fifo_count             number of queued commands
//   err                    sticky readback-mismatch flag
module sr_drive_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned HOLD  = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cmd_valid,
   input  logic [1:0]                     cmd_op,
   output logic                           cmd_ready,
   input  logic                           Q,
   input  logic                           err_clr,
   output logic                           S,
   output logic                           R,
   output logic                           busy,
   output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
   output logic                           err
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_TGL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          mem_q [DEPTH];
   logic [PTR_W-1:0]    wptr_q, rptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                s_q, s_d;
   logic                r_q, r_d;
   logic                exp_q, exp_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                err_q;

   logic                push_c;
   logic                pop_c;
   logic                set_c;
   logic [1:0]          head_op_c;

   assign head_op_c = mem_q[rptr_q];

   // Nops complete the handshake without being queued.
   assign push_c = cmd_valid && ready_q && (cmd_op != OP_NOP);

   // Popping from CHECK as well as IDLE lets back-to-back pulses start every
   // HOLD+1 cycles, leaving exactly one low guard cycle between them.
   assign pop_c  = (state_q != ST_DRIVE) && (count_q != '0);

   // Toggle resolves against the live flop output at the pop edge.
   assign set_c  = (head_op_c == OP_SET) || ((head_op_c == OP_TGL) && !Q);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pop_c) state_d = ST_DRIVE;
         ST_DRIVE: if (hold_q == '0) state_d = ST_CHECK;
         ST_CHECK: state_d = pop_c ? ST_DRIVE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      s_d    = 1'b0;
      r_d    = 1'b0;
      hold_d = hold_q;
      exp_d  = exp_q;
      case (state_q)
         ST_DRIVE: begin
            if (hold_q != '0) begin
               s_d    = s_q;
               r_d    = r_q;
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         ST_IDLE, ST_CHECK: begin
            if (pop_c) begin
               s_d    = set_c;
               r_d    = !set_c;
               exp_d  = set_c;
               hold_d = HOLD_W'(HOLD - 1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      ready_d = (count_d != CNT_W'(DEPTH));
      busy_d  = (state_d != ST_IDLE) || (count_d != '0);
   end

   // Control and drive registers; S/R drop asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         hold_q  <= '0;
         exp_q   <= 1'b0;
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         s_q     <= s_d;
         r_q     <= r_d;
         hold_q  <= hold_d;
         exp_q   <= exp_d;
         count_q <= count_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         if (push_c) wptr_q <= wptr_q + PTR_W'(1);
         if (pop_c)  rptr_q <= rptr_q + PTR_W'(1);
      end
   end

   // FIFO storage; contents are qualified by count, so no reset needed.
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wptr_q] <= cmd_op;
   end

`ifdef SR_CHECK_EN
   logic mismatch_c;
   assign mismatch_c = (state_q == ST_CHECK) && (Q != exp_q);

   // Sticky error; a new mismatch wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (mismatch_c) begin
         err_q <= 1'b1;
      end else if (err_clr) begin
         err_q <= 1'b0;
      end
   end
`else
   logic unused_chk;
   assign unused_chk = ^{err_clr, exp_q};
   assign err_q      = 1'b0;
`endif

   assign S          = s_q;
   assign R          = r_q;
   assign cmd_ready  = ready_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;
   assign err        = err_q;

endmodule
